// File: rtl/trace_pkg.sv
// Shared definitions for the CPU trace capture block: record layout,
// flag bit positions and the capture handshake states.
package trace_pkg;

   localparam int RECORD_BYTES = 6;
   localparam int REC_W        = 8 * RECORD_BYTES;

   // Bit offsets of each byte field inside a packed record; pc is the most
   // significant byte so it leaves the serializer first.
   localparam int OFF_PC     = 40;
   localparam int OFF_OPCODE = 32;
   localparam int OFF_A      = 24;
   localparam int OFF_B      = 16;
   localparam int OFF_RESULT = 8;
   localparam int OFF_FLAGS  = 0;

   localparam int FLAG_CARRY  = 0;
   localparam int FLAG_BORROW = 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACK,
      ST_RELEASE
   } cap_state_e;

   typedef struct packed {
      logic [7:0] pc;
      logic [7:0] opcode;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] result;
      logic [7:0] flags;
   } trace_rec_t;

   function automatic logic [7:0] rec_byte(input logic [REC_W-1:0] rec,
                                           input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = rec[OFF_PC     +: 8];
         3'd1:    b = rec[OFF_OPCODE +: 8];
         3'd2:    b = rec[OFF_A      +: 8];
         3'd3:    b = rec[OFF_B      +: 8];
         3'd4:    b = rec[OFF_RESULT +: 8];
         default: b = rec[OFF_FLAGS  +: 8];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO with an occupancy count; read data is the
// current head, shown combinationally.
module trace_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 48
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [W-1:0]             wr_data,
   input  logic                     rd_en,
   output logic [W-1:0]             rd_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/cpu_trace_capture.sv
// Accepts one retired-instruction record per CPU handshake, buffers it and
// replays each record as six bytes on a valid/ready stream.
module cpu_trace_capture
   import trace_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   data_in,
   output logic                   next_out,
   input  logic [7:0]             pc_in,
   input  logic [7:0]             opcode_in,
   input  logic [7:0]             operand_a_in,
   input  logic [7:0]             operand_b_in,
   input  logic [7:0]             result_in,
   input  logic                   carry_in,
   input  logic                   borrow_in,
   output logic [7:0]             byte_out,
   output logic                   byte_valid,
   input  logic                   byte_ready,
   output logic                   byte_last,
   output logic [$clog2(DEPTH):0] record_count
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [2:0] LAST_IDX = 3'(RECORD_BYTES - 1);

   cap_state_e       state_q, state_d;
   logic             wr_en;
   logic             pop;
   logic             full;
   logic [2:0]       bidx;
   trace_rec_t       rec_in;
   logic [REC_W-1:0] head;

   always_comb begin
      rec_in                     = '0;
      rec_in.pc                  = pc_in;
      rec_in.opcode              = opcode_in;
      rec_in.a                   = operand_a_in;
      rec_in.b                   = operand_b_in;
      rec_in.result              = result_in;
      rec_in.flags[FLAG_CARRY]   = carry_in;
      rec_in.flags[FLAG_BORROW]  = borrow_in;
   end

   // Full uses the registered count, so a same-cycle pop never frees a slot early.
   assign full = (record_count == CW'(DEPTH));

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      wr_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (data_in && !full) begin
               wr_en   = 1'b1;
               state_d = ST_ACK;
            end
         end
         ST_ACK:     state_d = ST_RELEASE;
         ST_RELEASE: if (!data_in) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   assign next_out = (state_q == ST_ACK);

   trace_fifo #(
      .DEPTH (DEPTH),
      .W     (REC_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (rec_in),
      .rd_en   (pop),
      .rd_data (head),
      .count   (record_count)
   );

   assign byte_valid = (record_count != '0);
   assign byte_last  = byte_valid && (bidx == LAST_IDX);
   assign pop        = byte_valid && byte_ready && (bidx == LAST_IDX);
   // Zeroed when idle so the stream never shows stale or uninitialised storage.
   assign byte_out   = byte_valid ? rec_byte(head, bidx) : 8'h00;

   always_ff @(posedge clk) begin
      if (rst) begin
         bidx <= '0;
      end else if (byte_valid && byte_ready) begin
         bidx <= (bidx == LAST_IDX) ? 3'd0 : bidx + 3'd1;
      end
   end

endmodule

// File: tb/tb_cpu_trace_capture.sv
// Self-checking bench: a CPU-side driver offers records, a scoreboard of
// expected bytes is built from accepted records and compared to the stream.
module tb_cpu_trace_capture;
   import trace_pkg::*;

   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          data_in;
   logic          next_out;
   logic [7:0]    pc_in, opcode_in, operand_a_in, operand_b_in, result_in;
   logic          carry_in, borrow_in;
   logic [7:0]    byte_out;
   logic          byte_valid;
   logic          byte_ready;
   logic          byte_last;
   logic [CW-1:0] record_count;

   always #5 clk = ~clk;

   cpu_trace_capture #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .data_in      (data_in),
      .next_out     (next_out),
      .pc_in        (pc_in),
      .opcode_in    (opcode_in),
      .operand_a_in (operand_a_in),
      .operand_b_in (operand_b_in),
      .result_in    (result_in),
      .carry_in     (carry_in),
      .borrow_in    (borrow_in),
      .byte_out     (byte_out),
      .byte_valid   (byte_valid),
      .byte_ready   (byte_ready),
      .byte_last    (byte_last),
      .record_count (record_count)
   );

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] exp_b[$];
   bit         exp_l[$];
   logic [7:0] got_b[$];
   bit         got_l[$];
   int         got_cycles;
   int         stab_err;
   bit         accepted;
   logic       ack_after;

   // Reference model: each accepted record becomes six expected bytes.
   task automatic push_model(input logic [7:0] p, o, a, b, r, input bit c, input bit w);
      exp_b.push_back(p); exp_b.push_back(o); exp_b.push_back(a);
      exp_b.push_back(b); exp_b.push_back(r);
      exp_b.push_back(8'(2 * int'(w) + int'(c)));
      for (int i = 0; i < 6; i++) exp_l.push_back(i == 5);
   endtask

   task automatic offer(input logic [7:0] p, o, a, b, r, input bit c, input bit w,
                        input int budget);
      pc_in = p; opcode_in = o; operand_a_in = a; operand_b_in = b;
      result_in = r; carry_in = c; borrow_in = w;
      data_in = 1'b1;
      accepted = 1'b0;
      for (int i = 0; i < budget && !accepted; i++) begin
         @(negedge clk);
         if (next_out) accepted = 1'b1;
      end
      if (accepted) begin
         push_model(p, o, a, b, r, c, w);
         data_in = 1'b0;
         @(negedge clk);
         ack_after = next_out;
         @(negedge clk);
      end
   endtask

   // mode 0: ready always high, 1: random ready, 2: ready alternates 1,0,1,0
   task automatic collect(input int n, input int mode);
      logic [7:0] prev_b;
      bit         prev_stall;
      bit         r;
      int         budget;
      prev_b = '0; prev_stall = 1'b0; budget = 20 * n + 20;
      got_b.delete(); got_l.delete(); got_cycles = 0; stab_err = 0;
      while (got_b.size() < n && got_cycles < budget) begin
         case (mode)
            1:       r = 1'($urandom_range(0, 1));
            2:       r = (got_cycles % 2 == 0);
            default: r = 1'b1;
         endcase
         if (prev_stall && (!byte_valid || byte_out !== prev_b)) stab_err++;
         byte_ready = r;
         if (byte_valid && r) begin
            got_b.push_back(byte_out);
            got_l.push_back(byte_last);
         end
         prev_stall = byte_valid && !r;
         prev_b     = byte_out;
         got_cycles++;
         @(negedge clk);
      end
      byte_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; data_in = 1'b0; byte_ready = 1'b0;
      pc_in = '0; opcode_in = '0; operand_a_in = '0; operand_b_in = '0;
      result_in = '0; carry_in = 1'b0; borrow_in = 1'b0;
      repeat (3) @(negedge clk);
      vectors++; if (next_out !== 1'b0) begin miscompares++; $display("FAIL reset next_out got %b want 0", next_out); end
      vectors++; if (byte_valid !== 1'b0) begin miscompares++; $display("FAIL reset byte_valid got %b want 0", byte_valid); end
      vectors++; if (byte_last !== 1'b0) begin miscompares++; $display("FAIL reset byte_last got %b want 0", byte_last); end
      vectors++; if (byte_out !== 8'h00) begin miscompares++; $display("FAIL reset byte_out got %h want 00", byte_out); end
      vectors++; if (record_count !== '0) begin miscompares++; $display("FAIL reset record_count got %0d want 0", record_count); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      logic [7:0] eb; bit el;
      offer(8'h03, 8'h81, 8'h05, 8'h07, 8'h0C, 1'b0, 1'b0, 6);
      vectors++; if (!accepted) begin miscompares++; $display("FAIL single accept got 0 want 1"); end
      vectors++; if (ack_after !== 1'b0) begin miscompares++; $display("FAIL single next_out width: second cycle got %b want 0", ack_after); end
      vectors++; if (record_count !== CW'(1)) begin miscompares++; $display("FAIL single count got %0d want 1", record_count); end
      collect(6, 0);
      vectors++; if (got_b.size() != 6) begin miscompares++; $display("FAIL single byte count got %0d want 6", got_b.size()); end
      vectors++; if (got_cycles != 6) begin miscompares++; $display("FAIL single throughput cycles got %0d want 6", got_cycles); end
      foreach (got_b[i]) begin
         eb = (exp_b.size() > 0) ? exp_b.pop_front() : 8'hxx;
         el = (exp_l.size() > 0) ? exp_l.pop_front() : 1'b0;
         vectors++;
         if (got_b[i] !== eb || got_l[i] !== el) begin miscompares++; $display("FAIL single byte %0d got %h/%0d want %h/%0d", i, got_b[i], got_l[i], eb, el); end
      end
      vectors++; if (record_count !== '0) begin miscompares++; $display("FAIL single drained count got %0d want 0", record_count); end
   endtask

   task automatic test_stall();
      logic [7:0] p, o, a, b, r, eb; bit c, w, el, seen; int acks, wait_cyc;
      acks = 0; byte_ready = 1'b0;
      p = '0; o = '0; a = '0; b = '0; r = '0; c = 1'b0; w = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         p = 8'($urandom); o = 8'($urandom); a = 8'($urandom); b = 8'($urandom);
         r = 8'($urandom); c = 1'($urandom); w = 1'($urandom);
         offer(p, o, a, b, r, c, w, 6);
         if (accepted) acks++;
      end
      vectors++; if (acks != DEPTH) begin miscompares++; $display("FAIL stall ack count got %0d want %0d", acks, DEPTH); end
      vectors++; if (record_count !== CW'(DEPTH)) begin miscompares++; $display("FAIL stall full count got %0d want %0d", record_count, DEPTH); end
      vectors++; if (next_out !== 1'b0) begin miscompares++; $display("FAIL stall held next_out got %b want 0", next_out); end
      collect(6, 0);
      vectors++; if (got_b.size() != 6) begin miscompares++; $display("FAIL stall first drain got %0d want 6", got_b.size()); end
      foreach (got_b[i]) begin
         eb = (exp_b.size() > 0) ? exp_b.pop_front() : 8'hxx;
         el = (exp_l.size() > 0) ? exp_l.pop_front() : 1'b0;
         vectors++;
         if (got_b[i] !== eb || got_l[i] !== el) begin miscompares++; $display("FAIL stall head byte %0d got %h/%0d want %h/%0d", i, got_b[i], got_l[i], eb, el); end
      end
      seen = 1'b0; wait_cyc = 0;
      while (!seen && wait_cyc < 6) begin
         @(negedge clk); wait_cyc++;
         if (next_out) seen = 1'b1;
      end
      vectors++; if (!seen || wait_cyc != 1) begin miscompares++; $display("FAIL stall late ack seen %0d after %0d cycles want 1 after 1", seen, wait_cyc); end
      if (seen) push_model(p, o, a, b, r, c, w);
      data_in = 1'b0;
      repeat (2) @(negedge clk);
      vectors++; if (record_count !== CW'(DEPTH)) begin miscompares++; $display("FAIL stall refill count got %0d want %0d", record_count, DEPTH); end
      collect(6 * DEPTH, 1);
      vectors++; if (got_b.size() != 6 * DEPTH) begin miscompares++; $display("FAIL stall drain got %0d want %0d", got_b.size(), 6 * DEPTH); end
      foreach (got_b[i]) begin
         eb = (exp_b.size() > 0) ? exp_b.pop_front() : 8'hxx;
         el = (exp_l.size() > 0) ? exp_l.pop_front() : 1'b0;
         vectors++;
         if (got_b[i] !== eb || got_l[i] !== el) begin miscompares++; $display("FAIL stall byte %0d got %h/%0d want %h/%0d", i, got_b[i], got_l[i], eb, el); end
      end
   endtask

   task automatic test_held();
      logic [7:0] eb; bit el, seen; int pulses;
      pc_in = 8'h42; opcode_in = 8'h11; operand_a_in = 8'h22; operand_b_in = 8'h33;
      result_in = 8'h55; carry_in = 1'b1; borrow_in = 1'b0;
      data_in = 1'b1; seen = 1'b0;
      for (int i = 0; i < 6 && !seen; i++) begin
         @(negedge clk);
         if (next_out) seen = 1'b1;
      end
      vectors++; if (!seen) begin miscompares++; $display("FAIL held first ack got 0 want 1"); end
      push_model(8'h42, 8'h11, 8'h22, 8'h33, 8'h55, 1'b1, 1'b0);
      pulses = 0;
      repeat (5) begin
         @(negedge clk);
         if (next_out) pulses++;
      end
      vectors++; if (pulses != 0) begin miscompares++; $display("FAIL held extra acks got %0d want 0", pulses); end
      vectors++; if (record_count !== CW'(1)) begin miscompares++; $display("FAIL held count got %0d want 1", record_count); end
      vectors++; if (dut.state_q !== ST_RELEASE) begin miscompares++; $display("FAIL held state got %0d want RELEASE", dut.state_q); end
      data_in = 1'b0;
      @(negedge clk);
      vectors++; if (dut.state_q !== ST_IDLE) begin miscompares++; $display("FAIL held release state got %0d want IDLE", dut.state_q); end
      collect(6, 0);
      vectors++; if (got_b.size() != 6) begin miscompares++; $display("FAIL held bytes got %0d want 6", got_b.size()); end
      foreach (got_b[i]) begin
         eb = (exp_b.size() > 0) ? exp_b.pop_front() : 8'hxx;
         el = (exp_l.size() > 0) ? exp_l.pop_front() : 1'b0;
         vectors++;
         if (got_b[i] !== eb || got_l[i] !== el) begin miscompares++; $display("FAIL held byte %0d got %h/%0d want %h/%0d", i, got_b[i], got_l[i], eb, el); end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] eb; bit el;
      for (int k = 0; k < 2; k++)
         offer(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
               1'($urandom), 1'($urandom), 6);
      collect(12, 2);
      vectors++; if (stab_err != 0) begin miscompares++; $display("FAIL backpressure stability errors got %0d want 0", stab_err); end
      vectors++; if (got_b.size() != 12) begin miscompares++; $display("FAIL backpressure bytes got %0d want 12", got_b.size()); end
      foreach (got_b[i]) begin
         eb = (exp_b.size() > 0) ? exp_b.pop_front() : 8'hxx;
         el = (exp_l.size() > 0) ? exp_l.pop_front() : 1'b0;
         vectors++;
         if (got_b[i] !== eb || got_l[i] !== el) begin miscompares++; $display("FAIL backpressure byte %0d got %h/%0d want %h/%0d", i, got_b[i], got_l[i], eb, el); end
      end
   endtask

   task automatic test_flags();
      logic [7:0] eb; bit el;
      offer(8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 1'b1, 1'b1, 6);
      offer(8'h11, 8'h21, 8'h31, 8'h41, 8'h51, 1'b1, 1'b0, 6);
      collect(12, 1);
      vectors++; if (got_b.size() != 12) begin miscompares++; $display("FAIL flags bytes got %0d want 12", got_b.size()); end
      if (got_b.size() == 12) begin
         vectors++; if (got_b[5] !== 8'h03) begin miscompares++; $display("FAIL flags c1b1 got %h want 03", got_b[5]); end
         vectors++; if (got_b[11] !== 8'h01) begin miscompares++; $display("FAIL flags c1b0 got %h want 01", got_b[11]); end
      end
      foreach (got_b[i]) begin
         eb = (exp_b.size() > 0) ? exp_b.pop_front() : 8'hxx;
         el = (exp_l.size() > 0) ? exp_l.pop_front() : 1'b0;
         vectors++;
         if (got_b[i] !== eb || got_l[i] !== el) begin miscompares++; $display("FAIL flags byte %0d got %h/%0d want %h/%0d", i, got_b[i], got_l[i], eb, el); end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] eb; bit el;
      for (int k = 0; k < 2; k++)
         offer(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
               1'($urandom), 1'($urandom), 6);
      collect(3, 0);
      rst = 1'b1;
      @(negedge clk);
      vectors++; if (byte_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid byte_valid got %b want 0", byte_valid); end
      vectors++; if (record_count !== '0) begin miscompares++; $display("FAIL rstmid count got %0d want 0", record_count); end
      vectors++; if (next_out !== 1'b0) begin miscompares++; $display("FAIL rstmid next_out got %b want 0", next_out); end
      rst = 1'b0;
      exp_b.delete(); exp_l.delete();
      @(negedge clk);
      offer(8'hA5, 8'h5A, 8'h01, 8'h02, 8'h03, 1'b0, 1'b1, 6);
      collect(6, 0);
      vectors++; if (got_b.size() != 6) begin miscompares++; $display("FAIL rstmid bytes got %0d want 6", got_b.size()); end
      foreach (got_b[i]) begin
         eb = (exp_b.size() > 0) ? exp_b.pop_front() : 8'hxx;
         el = (exp_l.size() > 0) ? exp_l.pop_front() : 1'b0;
         vectors++;
         if (got_b[i] !== eb || got_l[i] !== el) begin miscompares++; $display("FAIL rstmid byte %0d got %h/%0d want %h/%0d", i, got_b[i], got_l[i], eb, el); end
      end
   endtask

   task automatic test_random();
      logic [7:0] eb; bit el; int k;
      for (int round = 0; round < 6; round++) begin
         k = $urandom_range(1, DEPTH);
         for (int j = 0; j < k; j++) begin
            offer(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom), 6);
            vectors++; if (!accepted) begin miscompares++; $display("FAIL random accept round %0d rec %0d got 0 want 1", round, j); end
         end
         collect(6 * k, 1);
         vectors++; if (got_b.size() != 6 * k) begin miscompares++; $display("FAIL random bytes got %0d want %0d", got_b.size(), 6 * k); end
         vectors++; if (stab_err != 0) begin miscompares++; $display("FAIL random stability errors got %0d want 0", stab_err); end
         foreach (got_b[i]) begin
            eb = (exp_b.size() > 0) ? exp_b.pop_front() : 8'hxx;
            el = (exp_l.size() > 0) ? exp_l.pop_front() : 1'b0;
            vectors++;
            if (got_b[i] !== eb || got_l[i] !== el) begin miscompares++; $display("FAIL random byte %0d got %h/%0d want %h/%0d", i, got_b[i], got_l[i], eb, el); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stall();
      test_held();
      test_backpressure();
      test_flags();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
